// File: rtl/alu_result_stage.sv
// Purpose : registered result stage behind the 8-bit AU/LU; stores result + Z/N/C/V, counts signed overflows.
// Latency : an entry pushed at edge N is visible at the output after edge N; no input-to-output bypass.
// Backpres: in_ready = !full (state only, no path from out_ready); head holds while out_ready=0.
//
// Ports:
//   clk, reset                     single clock, asynchronous active-high reset
//   in_valid/in_ready              producer handshake; in_unit/in_ctrl/in_a/in_b/in_result/in_carry payload
//   out_valid/out_ready            consumer handshake; out_result/out_flags {Z,N,C,V} of head entry
//   ovf_count/ovf_clear            saturating count of accepted V=1 entries, synchronous clear

// Generic circular FIFO with wrap-bit pointers.
// Latency: head_data reflects a push into an empty FIFO after the write edge.
// Backpressure: push ignored when full, pop ignored when empty.
module alu_result_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: it is only observed through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

  assign head_data = mem[rptr[AW-1:0]];

endmodule

module alu_result_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_unit,
  input  logic [1:0]       in_ctrl,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [7:0]       in_result,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clear
);

  typedef struct packed {
    logic [7:0] result;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t in_entry;
  entry_t head;
  entry_t last_q;
  entry_t shown;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  logic   ovf;
  logic   a7;
  logic   b7;
  logic   r7;

  // Only the sign bits of the operands matter for overflow detection.
  logic   unused_bits;
  assign unused_bits = ^{in_a[6:0], in_b[6:0]};

  assign a7 = in_a[7];
  assign b7 = in_b[7];
  assign r7 = in_result[7];

  // Signed overflow: AU ctrl 00 add, 01 inc, 10 sub, 11 dec; never for LU.
  always_comb begin
    ovf = 1'b0;
    if (!in_unit) begin
      case (in_ctrl)
        2'b00: ovf = (a7 & b7 & ~r7) | (~a7 & ~b7 & r7);
        2'b01: ovf = ~a7 & r7;
        2'b10: ovf = (a7 & ~b7 & ~r7) | (~a7 & b7 & r7);
        2'b11: ovf = a7 & ~r7;
      endcase
    end
  end

  always_comb begin
    in_entry.result = in_result;
    in_entry.z      = (in_result == 8'h00);
    in_entry.n      = r7;
    in_entry.c      = in_unit ? 1'b0 : in_carry;
    in_entry.v      = ovf;
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  alu_result_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_entry),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head_data (head)
  );

  // Remembers the last popped entry so the outputs hold it while empty
  // instead of exposing whatever stale slot the read pointer lands on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= '0;
    end else if (pop) begin
      last_q <= head;
    end
  end

  assign shown      = empty ? last_q : head;
  assign out_result = shown.result;
  assign out_flags  = {shown.z, shown.n, shown.c, shown.v};

  // Clear wins over a same-cycle increment; increment saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (ovf_clear) begin
      ovf_count <= '0;
    end else if (push && ovf && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_unit = 1'b0;
  logic [1:0]       in_ctrl = 2'b00;
  logic [7:0]       in_a = 8'h00;
  logic [7:0]       in_b = 8'h00;
  logic [7:0]       in_result = 8'h00;
  logic             in_carry = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_result;
  logic [3:0]       out_flags;
  logic [CNT_W-1:0] ovf_count;
  logic             ovf_clear = 1'b0;

  alu_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_unit    (in_unit),
    .in_ctrl    (in_ctrl),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_result  (in_result),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .ovf_count  (ovf_count),
    .ovf_clear  (ovf_clear)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: queue of {result, flags}, last popped entry, overflow count.
  logic [11:0] mq[$];
  logic [11:0] m_last = 12'h000;
  int          m_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Flags from the arithmetic meaning of the op: V is signed range overflow.
  function automatic logic [3:0] ref_flags(input logic unit, input logic [1:0] ctrl,
                                           input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] r, input logic c);
    int sa, sb, s;
    logic v, cf;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = 0;
    if (unit) begin
      v  = 1'b0;
      cf = 1'b0;
    end else begin
      case (ctrl)
        2'd0: s = sa + sb;
        2'd1: s = sa + 1;
        2'd2: s = sa - sb;
        default: s = sa - 1;
      endcase
      v  = (s > 127) || (s < -128);
      cf = c;
    end
    return {r == 8'h00, r[7], cf, v};
  endfunction

  // What the ALU itself would present for an op.
  task automatic alu_eval(input logic unit, input logic [1:0] ctrl, input logic [7:0] a,
                          input logic [7:0] b, output logic [7:0] r, output logic c);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    c  = 1'b0;
    r  = 8'h00;
    if (!unit) begin
      case (ctrl)
        2'd0: begin r = 8'(ia + ib); c = (ia + ib) > 255; end
        2'd1: begin r = 8'(ia + 1);  c = (ia + 1) > 255;  end
        2'd2: begin r = 8'(ia - ib); c = ia < ib;         end
        default: begin r = 8'(ia - 1); c = ia == 0;       end
      endcase
    end else begin
      case (ctrl)
        2'd0: r = a & b;
        2'd1: r = a | b;
        2'd2: r = a ^ b;
        default: r = ~a;
      endcase
    end
  endtask

  task automatic check_outs();
    logic [11:0] e;
    e = (mq.size() != 0) ? mq[0] : m_last;
    check("out_valid", out_valid, mq.size() != 0);
    check("in_ready", in_ready, mq.size() < DEPTH);
    check("out_result", out_result, e[11:4]);
    check("out_flags", out_flags, e[3:0]);
    check("ovf_count", ovf_count, m_cnt);
  endtask

  // One clock: entered and left just after a falling edge.
  task automatic cycle(input logic v, input logic unit, input logic [1:0] ctrl,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                       input logic c, input logic ordy, input logic clr);
    logic push, pop;
    logic [3:0] f;
    check_outs();
    in_valid  = v;
    in_unit   = unit;
    in_ctrl   = ctrl;
    in_a      = a;
    in_b      = b;
    in_result = r;
    in_carry  = c;
    out_ready = ordy;
    ovf_clear = clr;
    push = v && (mq.size() < DEPTH);
    pop  = ordy && (mq.size() != 0);
    f    = ref_flags(unit, ctrl, a, b, r, c);
    @(posedge clk);
    if (pop) m_last = mq.pop_front();
    if (push) mq.push_back({r, f});
    if (clr) m_cnt = 0;
    else if (push && f[0] && m_cnt < CNT_MAX) m_cnt++;
    @(negedge clk);
  endtask

  task automatic op(input logic v, input logic unit, input logic [1:0] ctrl,
                    input logic [7:0] a, input logic [7:0] b, input logic ordy, input logic clr);
    logic [7:0] r;
    logic c;
    alu_eval(unit, ctrl, a, b, r, c);
    cycle(v, unit, ctrl, a, b, r, c, ordy, clr);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, ordy, 1'b0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = 12'h000;
    m_cnt  = 0;
  endtask

  initial begin
    // in_valid high during reset must not load anything.
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_result", out_result, 8'h00);
    check("rst_out_flags", out_flags, 4'h0);
    check("rst_ovf_count", ovf_count, 0);

    // add 7F+01 -> 80, signed overflow.
    op(1'b1, 1'b0, 2'd0, 8'h7F, 8'h01, 1'b0, 1'b0);
    check("add_valid", out_valid, 1'b1);
    check("add_result", out_result, 8'h80);
    check("add_flags", out_flags, 4'b0101);
    check("add_ovf", ovf_count, 1);

    // sub 00-01 (borrow) popping the add, then LU xor with carry input set.
    op(1'b1, 1'b0, 2'd2, 8'h00, 8'h01, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 2'd2, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0);
    check("sub_flags", out_flags, 4'b0110);
    check("full_in_ready", in_ready, 1'b0);
    idle(1'b1);
    check("xor_flags", out_flags, 4'b1000);
    idle(1'b1);
    check("empty_hold_flags", out_flags, 4'b1000);

    // Full: third push refused; one pop frees a slot.
    op(1'b1, 1'b1, 2'd1, 8'h11, 8'h22, 1'b0, 1'b0);
    op(1'b1, 1'b1, 2'd0, 8'hF0, 8'h3C, 1'b0, 1'b0);
    op(1'b1, 1'b1, 2'd3, 8'h0F, 8'h00, 1'b0, 1'b0);
    check("third_refused_result", out_result, 8'h33);
    idle(1'b1);
    check("pop_frees_slot", in_ready, 1'b1);
    check("second_head", out_result, 8'h30);
    idle(1'b1);

    // Back-to-back stream across pointer wrap.
    for (int i = 0; i < 8; i++)
      op(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // Saturation, then clear beating a same-cycle V=1 push.
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 2'd1, 8'h7F, 8'h00, 1'b1, 1'b0);
    check("ovf_saturated", ovf_count, CNT_MAX);
    op(1'b1, 1'b0, 2'd1, 8'h7F, 8'h00, 1'b1, 1'b1);
    check("ovf_clear_priority", ovf_count, 0);
    idle(1'b1);

    // Asynchronous reset with two entries queued.
    op(1'b1, 1'b0, 2'd1, 8'h7F, 8'h00, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'd3, 8'h80, 8'h00, 1'b0, 1'b0);
    check("pre_reset_ovf", ovf_count, 2);
    #2 reset = 1'b1;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_out_flags", out_flags, 4'h0);
    check("async_out_result", out_result, 8'h00);
    check("async_ovf", ovf_count, 0);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    check("post_reset_in_ready", in_ready, 1'b1);
    check("post_reset_out_valid", out_valid, 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] r;
      logic c;
      logic unit;
      logic [1:0] ctrl;
      unit = 1'($urandom_range(0, 1));
      ctrl = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = 8'h7F;
        1: a = 8'h80;
        default: a = 8'($urandom);
      endcase
      b = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      alu_eval(unit, ctrl, a, b, r, c);
      if (unit) c = 1'($urandom_range(0, 1));
      cycle(1'($urandom_range(0, 3) != 0), unit, ctrl, a, b, r, c,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
    check_outs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
